// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module     : vga_timing_if
// Description: Bundle between the VGA raster timing generator and its
//              consumers (pixel renderer / DAC pins). The generator drives
//              the raster outputs and receives the pixel clock-enable.
// Revision   : 1.0 - initial release
// ============================================================================
interface vga_timing_if #(
    parameter int CNT_W  = 11,
    parameter int FCNT_W = 8
);
    logic              pix_ce;
    logic              display_enable;
    logic              hsync;
    logic              vsync;
    logic [CNT_W-1:0]  x_pos;
    logic [CNT_W-1:0]  y_pos;
    logic              line_start;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_cnt;

    // Timing generator side
    modport master (
        input  pix_ce,
        output display_enable,
        output hsync,
        output vsync,
        output x_pos,
        output y_pos,
        output line_start,
        output frame_start,
        output frame_cnt
    );

    // Renderer / consumer side
    modport slave (
        output pix_ce,
        input  display_enable,
        input  hsync,
        input  vsync,
        input  x_pos,
        input  y_pos,
        input  line_start,
        input  frame_start,
        input  frame_cnt
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module     : vga_timing_gen
// Description: Parametrised VGA raster timing generator. Walks an h/v raster
//              one pixel per pix_ce edge and produces registered display
//              enable, syncs, pixel coordinates, line/frame strobes and a
//              completed-frame counter (one pixel of latency).
// Revision   : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 56,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 37,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 11,
    parameter int FCNT_W   = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    vga_timing_if.master  vga
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Window bounds kept 32 bits wide so an end bound equal to 2**CNT_W
    // (zero back porch with a full-range counter) is not truncated to 0.
    localparam logic [31:0] C_H_ACTIVE = 32'(H_ACTIVE);
    localparam logic [31:0] C_V_ACTIVE = 32'(V_ACTIVE);
    localparam logic [31:0] C_HS_START = 32'(HS_START);
    localparam logic [31:0] C_HS_END   = 32'(HS_END);
    localparam logic [31:0] C_VS_START = 32'(VS_START);
    localparam logic [31:0] C_VS_END   = 32'(VS_END);
    localparam logic [31:0] C_H_LAST   = 32'(H_TOTAL - 1);
    localparam logic [31:0] C_V_LAST   = 32'(V_TOTAL - 1);

    // Refuse to build a generator whose counters cannot hold the raster
    generate
        if (CNT_W < 1 || CNT_W > 31 || FCNT_W < 1 ||
            H_ACTIVE < 1 || H_SYNC < 1 || H_FP < 0 || H_BP < 0 ||
            V_ACTIVE < 1 || V_SYNC < 1 || V_FP < 0 || V_BP < 0 ||
            H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_params
            $fatal(1, "vga_timing_gen: illegal parameter set");
        end
    endgenerate

    // Raster position counters
    logic [CNT_W-1:0]  h_q, h_d;
    logic [CNT_W-1:0]  v_q, v_d;

    // Registered outputs
    logic              de_q, de_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    logic              ls_q, ls_d;
    logic              fs_q, fs_d;
    logic [FCNT_W-1:0] fc_q, fc_d;

    // Decoded raster position
    logic [31:0] w_h_ext;
    logic [31:0] w_v_ext;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_h_vis;
    logic        w_v_vis;
    logic        w_h_sync;
    logic        w_v_sync;

    assign w_h_ext  = 32'(h_q);
    assign w_v_ext  = 32'(v_q);
    assign w_h_last = (w_h_ext == C_H_LAST);
    assign w_v_last = (w_v_ext == C_V_LAST);
    assign w_h_vis  = (w_h_ext < C_H_ACTIVE);
    assign w_v_vis  = (w_v_ext < C_V_ACTIVE);
    assign w_h_sync = (w_h_ext >= C_HS_START) && (w_h_ext < C_HS_END);
    assign w_v_sync = (w_v_ext >= C_VS_START) && (w_v_ext < C_VS_END);

    // Advance the raster by one pixel per enabled clock, wrapping line and frame
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (vga.pix_ce) begin
            if (w_h_last) begin
                h_d = '0;
                if (w_v_last) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end
    end

    // Decode the pre-edge position into next output values; strobes self-clear
    always_comb begin
        de_d = de_q;
        hs_d = hs_q;
        vs_d = vs_q;
        x_d  = x_q;
        y_d  = y_q;
        fc_d = fc_q;
        ls_d = 1'b0;
        fs_d = 1'b0;
        if (vga.pix_ce) begin
            de_d = w_h_vis && w_v_vis;
            x_d  = (w_h_vis && w_v_vis) ? h_q : '0;
            y_d  = (w_h_vis && w_v_vis) ? v_q : '0;
            hs_d = w_h_sync ? HS_POL : ~HS_POL;
            vs_d = w_v_sync ? VS_POL : ~VS_POL;
            ls_d = (h_q == '0);
            fs_d = (h_q == '0) && (v_q == '0);
            if (w_h_last && w_v_last) begin
                fc_d = fc_q + FCNT_W'(1);
            end
        end
    end

    // State and output registers, asynchronously cleared to the idle raster
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            de_q <= 1'b0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
            x_q  <= '0;
            y_q  <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            fc_q <= '0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            x_q  <= x_d;
            y_q  <= y_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            fc_q <= fc_d;
        end
    end

    assign vga.display_enable = de_q;
    assign vga.hsync          = hs_q;
    assign vga.vsync          = vs_q;
    assign vga.x_pos          = x_q;
    assign vga.y_pos          = y_q;
    assign vga.line_start     = ls_q;
    assign vga.frame_start    = fs_q;
    assign vga.frame_cnt      = fc_q;

endmodule
`default_nettype wire
